ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO.
// Define EX_MULDIV_DIVIDER_EN to build the divider datapath (DIV/DIVU, DivByZero).
module ex_muldiv_unit #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [NBits-1:0] OperandA,
  input  logic [NBits-1:0] OperandB,
  input  logic             Flush,
  input  logic             HiLoSel,
  output logic [NBits-1:0] HI,
  output logic [NBits-1:0] LO,
  output logic [NBits-1:0] ReadResult,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(NBits) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state, stateNext;
  logic [CW-1:0]    count;
  logic [NBits-1:0] acc, qReg, bReg;
  logic             negRes;

  logic             take, launch, isMul, signedOp, aNeg, bNeg, lastIter;
  logic [NBits-1:0] aMag, bMag;
  logic [NBits:0]   mulSum;
  logic [2*NBits-1:0] product, mulRes;

`ifdef EX_MULDIV_DIVIDER_EN
  logic             opDiv, negRem, divZero, isDiv;
  logic [NBits:0]   divShift, divDiff;
`endif

  always_comb begin
    take     = (state == IDLE) && Start && !Flush;
    isMul    = (MDOp == 3'd1) || (MDOp == 3'd2);
    signedOp = (MDOp == 3'd1) || (MDOp == 3'd3);
`ifdef EX_MULDIV_DIVIDER_EN
    isDiv    = (MDOp == 3'd3) || (MDOp == 3'd4);
    launch   = take && (isMul || isDiv);
`else
    launch   = take && isMul;
`endif
    aNeg     = signedOp && OperandA[NBits-1];
    bNeg     = signedOp && OperandB[NBits-1];
    aMag     = aNeg ? -OperandA : OperandA;
    bMag     = bNeg ? -OperandB : OperandB;
    lastIter = (count == CW'(NBits - 1));
    // {acc,qReg} is the double-width product shifting right as multiplier bits retire
    mulSum   = {1'b0, acc} + (qReg[0] ? {1'b0, bReg} : '0);
    product  = {acc, qReg};
    mulRes   = negRes ? -product : product;
`ifdef EX_MULDIV_DIVIDER_EN
    // Partial remainder stays below the divisor, so N+1 bits hold the trial and its borrow
    divShift = {acc, qReg[NBits-1]};
    divDiff  = divShift - {1'b0, bReg};
`endif
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (launch) stateNext = RUN;
      RUN:     if (Flush) stateNext = IDLE;
               else if (lastIter) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      qReg    <= '0;
      bReg    <= '0;
      negRes  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
`ifdef EX_MULDIV_DIVIDER_EN
      opDiv   <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (launch) begin
        count   <= '0;
        acc     <= '0;
        qReg    <= aMag;
        bReg    <= bMag;
        negRes  <= aNeg ^ bNeg;
`ifdef EX_MULDIV_DIVIDER_EN
        opDiv   <= isDiv;
        negRem  <= aNeg;
        divZero <= (OperandB == '0);
`endif
      end else if (state == RUN) begin
        count <= count + CW'(1);
`ifdef EX_MULDIV_DIVIDER_EN
        if (opDiv) begin
          acc  <= divDiff[NBits] ? divShift[NBits-1:0] : divDiff[NBits-1:0];
          qReg <= {qReg[NBits-2:0], ~divDiff[NBits]};
        end else
`endif
          {acc, qReg} <= {mulSum, qReg[NBits-1:1]};
      end

      if (take && MDOp == 3'd5) HI <= OperandA;
      if (take && MDOp == 3'd6) LO <= OperandA;

      if (state == FIX && !Flush) begin
`ifdef EX_MULDIV_DIVIDER_EN
        // Zero divisor leaves the dividend magnitude in acc, so the sign fix restores it
        if (opDiv) begin
          LO <= divZero ? '1 : (negRes ? -qReg : qReg);
          HI <= negRem ? -acc : acc;
        end else
`endif
          {HI, LO} <= mulRes;
      end
    end
  end

  assign ReadResult = HiLoSel ? HI : LO;
  assign Busy       = (state != IDLE);
  assign Done       = (state == FIX) && !Flush;
`ifdef EX_MULDIV_DIVIDER_EN
  assign DivByZero  = Done && opDiv && divZero;
`else
  assign DivByZero  = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: scoreboard of expected HI/LO, latency, flush and reset checks.
module tb_ex_muldiv_unit;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic [2:0]    MDOp = 3'd0;
  logic [NB-1:0] OperandA = '0;
  logic [NB-1:0] OperandB = '0;
  logic          Flush = 1'b0;
  logic          HiLoSel = 1'b0;
  logic [NB-1:0] HI, LO, ReadResult;
  logic          Busy, Done, DivByZero;

  int nAsserts = 0;
  int nFails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } expT;
  expT sb[$];

  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  ex_muldiv_unit #(.NBits(NB)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush), .HiLoSel(HiLoSel),
    .HI(HI), .LO(LO), .ReadResult(ReadResult), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                      input logic edz);
    expT e;
    int busyCnt = 0, doneCnt = 0, dzCnt = 0, dzWithDone = 0;
    bit ended = 0;
    e.hi = eh; e.lo = el; e.dz = edz;
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b1; MDOp = op; OperandA = a; OperandB = b;
    for (int i = 0; i < NB + 20; i++) begin
      @(negedge clk);
      if (i == 0) begin Start = 1'b0; OperandA = $urandom; OperandB = $urandom; end
      if (i == 3) begin Start = 1'b1; MDOp = 3'd2; end
      if (i == 4) Start = 1'b0;
      if (Busy) busyCnt++;
      if (Done) doneCnt++;
      if (DivByZero) dzCnt++;
      if (DivByZero && Done) dzWithDone++;
      if (!Busy) begin ended = 1; break; end
    end
    MDOp = 3'd0;
    e = sb.pop_front();
    chk({tag, " ended"}, 32'(ended), 32'd1);
    chk({tag, " busy cycles"}, 32'(busyCnt), 32'(NB + 1));
    chk({tag, " done pulses"}, 32'(doneCnt), 32'd1);
    chk({tag, " divbyzero pulses"}, 32'(dzCnt), 32'(e.dz));
    chk({tag, " divbyzero with done"}, 32'(dzWithDone), 32'(e.dz));
    chk({tag, " HI"}, HI, e.hi);
    chk({tag, " LO"}, LO, e.lo);
    mHi = e.hi; mLo = e.lo;
  endtask

  task automatic noopCheck(input string tag, input logic [2:0] op);
    bit busySeen = 0, doneSeen = 0;
    @(negedge clk);
    Start = 1'b1; MDOp = op; OperandA = $urandom; OperandB = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) Start = 1'b0;
      busySeen |= Busy;
      doneSeen |= Done;
    end
    MDOp = 3'd0;
    chk({tag, " busy"}, 32'(busySeen), 32'd0);
    chk({tag, " done"}, 32'(doneSeen), 32'd0);
    chk({tag, " HI"}, HI, mHi);
    chk({tag, " LO"}, LO, mLo);
  endtask

  task automatic moveTo(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic fl);
    @(negedge clk);
    Start = 1'b1; MDOp = op; OperandA = a; Flush = fl;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0; MDOp = 3'd0;
    if (!fl && op == 3'd5) mHi = a;
    if (!fl && op == 3'd6) mLo = a;
    chk({tag, " busy"}, 32'(Busy), 32'd0);
    chk({tag, " done"}, 32'(Done), 32'd0);
    chk({tag, " HI"}, HI, mHi);
    chk({tag, " LO"}, LO, mLo);
  endtask

  task automatic flushAt(input string tag, input int n);
    int busyCnt = 0;
    bit doneSeen = 0, reached = 0;
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd1; OperandA = 32'h1234_5678; OperandB = 32'h9ABC_DEF0;
    for (int i = 0; i < NB + 10; i++) begin
      @(negedge clk);
      if (i == 0) begin Start = 1'b0; MDOp = 3'd0; end
      if (Busy) busyCnt++;
      if (busyCnt == n) begin
        Flush = 1'b1; #1;
        doneSeen |= Done;
        reached = 1;
        break;
      end
      doneSeen |= Done;
    end
    @(negedge clk);
    Flush = 1'b0;
    chk({tag, " reached"}, 32'(reached), 32'd1);
    chk({tag, " busy after flush"}, 32'(Busy), 32'd0);
    repeat (3) begin @(negedge clk); doneSeen |= Done; end
    chk({tag, " done"}, 32'(doneSeen), 32'd0);
    chk({tag, " HI"}, HI, mHi);
    chk({tag, " LO"}, LO, mLo);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    longint sa, sb2;

    #2 reset = 1'b0;
    #1;
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset done", 32'(Done), 32'd0);
    chk("reset divbyzero", 32'(DivByZero), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    doOp("mult vec", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    doOp("multu vec", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    doOp("mult minneg", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      a = $urandom; b = $urandom;
      sa = longint'($signed(a)); sb2 = longint'($signed(b));
      p = 64'(sa * sb2);
      doOp("mult rand", 3'd1, a, b, p[63:32], p[31:0], 1'b0);
      p = {32'd0, a} * {32'd0, b};
      doOp("multu rand", 3'd2, a, b, p[63:32], p[31:0], 1'b0);
    end

`ifdef EX_MULDIV_DIVIDER_EN
    doOp("div neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    doOp("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    doOp("divu zero", 3'd4, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    doOp("div zero", 3'd3, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      a = $urandom; b = ($urandom >> $urandom_range(0, 28)) | 32'd1;
      if (a == 32'h8000_0000) a = 32'd1;
      begin
        int qa, qb;
        qa = $signed(a); qb = $signed(b);
        doOp("div rand", 3'd3, a, b, 32'(qa % qb), 32'(qa / qb), 1'b0);
      end
      doOp("divu rand", 3'd4, a, b, a % b, a / b, 1'b0);
    end
`else
    noopCheck("div disabled", 3'd3);
    noopCheck("divu disabled", 3'd4);
`endif
    noopCheck("op none", 3'd0);
    noopCheck("op reserved", 3'd7);

    HiLoSel = 1'b1; #1;
    chk("readresult hi", ReadResult, mHi);
    HiLoSel = 1'b0; #1;
    chk("readresult lo", ReadResult, mLo);

    moveTo("mthi", 3'd5, 32'h0BAD_BEEF, 1'b0);
    moveTo("mtlo", 3'd6, 32'hCAFE_F00D, 1'b0);
    moveTo("mthi flushed", 3'd5, 32'h1111_2222, 1'b1);
    flushAt("flush run", 10);
    flushAt("flush fix", NB + 1);

    @(negedge clk);
    Start = 1'b1; MDOp = 3'd1; OperandA = 32'd5; OperandB = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    mHi = '0; mLo = '0;
    chk("reset midrun busy", 32'(Busy), 32'd0);
    chk("reset midrun done", 32'(Done), 32'd0);
    chk("reset midrun HI", HI, 32'd0);
    chk("reset midrun LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    moveTo("mtlo after reset", 3'd6, 32'h0000_1357, 1'b0);
    doOp("mult after reset", 3'd2, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
